// File: rtl/queue_sequencer_pkg.sv
// Shared types and default timing for the queue sequencer.
// Holds the controller state encoding, the byte type and the default
// bit period / gap / depth constants used by the top-level parameters.
package queue_sequencer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WGAP,
    DEQ,
    DGAP
  } state_t;

  localparam int DEF_BIT_PERIOD = 15;
  localparam int DEF_GAP_CYCLES = 50;
  localparam int DEF_DEPTH      = 8;

  // Counter width able to hold the larger of the two timing spans.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational from req.
// Latency: 0 cycles (grant), history updates on the accept edge.
// Backpressure: none of its own; history only advances when the caller accepts.
// Ports: clock1M/reset clock and async active-low reset; req[0]=A, req[1]=B;
//        accept = granted requester was taken this cycle; grant one-hot (or 0).
module rr_arbiter2 (
  input  logic       clock1M,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 when B won the most recent accepted grant; reset to B so A wins the first tie.
  logic last_b;

  always_comb begin
    grant = 2'b00;
    if (req[0] && req[1]) begin
      grant = last_b ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      last_b <= 1'b1;
    end else if (accept) begin
      last_b <= grant[1];
    end
  end

endmodule

// File: rtl/queue_sequencer.sv
// Serialises bytes from two producers into a downstream queue and services dequeues.
// Latency: write occupies 8*BIT_PERIOD + GAP_CYCLES clocks; dequeue BIT_PERIOD + GAP_CYCLES.
// Backpressure: ready only in IDLE, for the granted producer, with room and no serviceable dequeue.
// Ports: clock1M, reset (async active-low); req_a/req_b valid/data/ready producers;
//        deq_req/deq_ack/deq_data/deq_err dequeue handshake; q_data_in/q_write_in/
//        q_dequeue_in/q_data_out queue side; occupancy/full/empty fill state.
module queue_sequencer
  import queue_sequencer_pkg::*;
#(
  parameter int BIT_PERIOD = DEF_BIT_PERIOD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic       clock1M,
  input  logic       reset,
  input  logic       req_a_valid,
  input  byte_t      req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  byte_t      req_b_data,
  output logic       req_b_ready,
  input  logic       deq_req,
  output logic       deq_ack,
  output byte_t      deq_data,
  output logic       deq_err,
  output logic       q_data_in,
  output logic       q_write_in,
  output logic       q_dequeue_in,
  input  byte_t      q_data_out,
  output logic [3:0] occupancy,
  output logic       full,
  output logic       empty
);

  localparam int            CW        = cnt_width(BIT_PERIOD, GAP_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    DEPTH_OCC = 4'(DEPTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    shreg;     // remaining bits after the MSB has been driven
  logic          pending;
  logic          live;      // low for the first clock after reset so ready stays 0 in reset
  logic [1:0]    grant;
  logic          deq_now;
  logic          deq_ok;
  logic          can_write;
  logic          accept;
  byte_t         acc_data;

  // A request arriving this cycle counts as pending so IDLE reacts without an extra clock.
  assign deq_now     = pending | deq_req;
  assign deq_ok      = deq_now && (occupancy != 4'd0);
  assign can_write   = live && (state == IDLE) && !deq_ok && (occupancy < DEPTH_OCC);
  assign req_a_ready = can_write && grant[0];
  assign req_b_ready = can_write && grant[1];
  assign accept      = (req_a_valid && req_a_ready) || (req_b_valid && req_b_ready);
  assign acc_data    = grant[1] ? req_b_data : req_a_data;
  assign full        = (occupancy == DEPTH_OCC);
  assign empty       = (occupancy == 4'd0);

  rr_arbiter2 u_arb (
    .clock1M (clock1M),
    .reset   (reset),
    .req     ({req_b_valid, req_a_valid}),
    .accept  (accept),
    .grant   (grant)
  );

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      pending      <= 1'b0;
      live         <= 1'b0;
      occupancy    <= '0;
      q_data_in    <= 1'b0;
      q_write_in   <= 1'b0;
      q_dequeue_in <= 1'b0;
      deq_ack      <= 1'b0;
      deq_err      <= 1'b0;
      deq_data     <= '0;
    end else begin
      live    <= 1'b1;
      deq_ack <= 1'b0;
      deq_err <= 1'b0;
      // IDLE always consumes the request; elsewhere a single request is latched.
      pending <= (state == IDLE) ? 1'b0 : (pending | deq_req);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (deq_ok) begin
            state        <= DEQ;
            occupancy    <= occupancy - 4'd1;
            q_dequeue_in <= 1'b1;
          end else begin
            if (deq_now) begin
              // Empty queue: answer immediately with an error, deq_data untouched.
              deq_ack <= 1'b1;
              deq_err <= 1'b1;
            end
            if (accept) begin
              state      <= SEND;
              shreg      <= acc_data[6:0];
              bit_idx    <= '0;
              q_write_in <= 1'b1;
              q_data_in  <= acc_data[7];
            end
          end
        end
        SEND: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state      <= WGAP;
              q_write_in <= 1'b0;
              q_data_in  <= 1'b0;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              q_data_in <= shreg[6];
              shreg     <= {shreg[5:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WGAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (!full) occupancy <= occupancy + 4'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEQ: begin
          if (cnt == BIT_LAST) begin
            cnt          <= '0;
            state        <= DGAP;
            q_dequeue_in <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DGAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            deq_data <= q_data_out;
            deq_ack  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/queue_sequencer.md
QUEUE_SEQUENCER -- requirements
Module: queue_sequencer

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 15, clocks each serial bit is held on q_data_in.
REQ-002 SHALL have parameter GAP_CYCLES, default 50, idle clocks after each write or dequeue burst.
REQ-003 SHALL have parameter DEPTH, default 8, byte capacity of the downstream queue.
REQ-004 SHALL have port clock1M  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_a_valid/req_b_valid  in  1  producer A/B byte available.
REQ-007 SHALL have ports req_a_data/req_b_data  in  8  producer A/B byte.
REQ-008 SHALL have ports req_a_ready/req_b_ready  out  1  byte accepted when valid&&ready.
REQ-009 SHALL have port deq_req  in  1  one-cycle dequeue request pulse.
REQ-010 SHALL have port deq_ack  out  1  one-cycle pulse, dequeue finished.
REQ-011 SHALL have port deq_data  out  8  dequeued byte, valid with deq_ack, held until next ack.
REQ-012 SHALL have port deq_err  out  1  valid with deq_ack; 1 = request made while empty.
REQ-013 SHALL have ports q_data_in, q_write_in, q_dequeue_in  out  1  drive queue serial data, write enable, dequeue.
REQ-014 SHALL have port q_data_out  in  8  queue head byte.
REQ-015 SHALL have ports occupancy  out  4, full  out  1, empty  out  1  controller-tracked fill state.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, WGAP, DEQ, DGAP.
REQ-017 IDLE: pending dequeue with occupancy>0 -> DEQ; else if any valid and occupancy<DEPTH -> SEND via grant; dequeue has priority over writes.
REQ-018 ready SHALL be asserted only in IDLE, only for the granted requester, only when no dequeue is serviceable and occupancy<DEPTH.
REQ-019 Grant SHALL be round-robin between A and B: when both valid, the requester not granted last wins; a lone valid requester always wins.
REQ-020 SEND: byte shifted out MSB first, each bit held exactly BIT_PERIOD clocks, q_write_in=1 for exactly 8*BIT_PERIOD clocks starting the cycle after acceptance.
REQ-021 WGAP: q_write_in=0, q_data_in=0 for GAP_CYCLES clocks; occupancy increments on WGAP exit; -> IDLE.
REQ-022 DEQ: q_dequeue_in=1 for BIT_PERIOD clocks; occupancy decrements on DEQ entry.
REQ-023 DGAP: GAP_CYCLES clocks, then q_data_out captured into deq_data, deq_ack pulsed with deq_err=0; -> IDLE.
REQ-024 deq_req SHALL set a single pending flag in any state; a second request while pending SHALL be ignored.
REQ-025 Pending request with occupancy=0 in IDLE SHALL produce deq_ack with deq_err=1 next cycle, no q_dequeue_in pulse, deq_data unchanged.
REQ-026 full = (occupancy==DEPTH), empty = (occupancy==0); occupancy SHALL never exceed DEPTH nor underflow.
REQ-027 Requests arriving mid-SEND/DEQ SHALL wait; valid SHALL not be consumed until ready.

Reset
REQ-028 On reset low: state IDLE, occupancy 0, empty 1, full 0, pending cleared, all other outputs 0, deq_data 8'h00, last grant = B (A wins first tie).
REQ-029 Reset asserted mid-SEND SHALL drop q_write_in the same instant; the partial byte is not counted.

Structure
REQ-030 Package queue_sequencer_pkg SHALL hold the state enum, byte_t typedef, and default BIT_PERIOD/GAP_CYCLES/DEPTH constants.
REQ-031 Round-robin grant SHALL be a sub-module rr_arbiter2 (2 requests, grant, update-on-accept).

Verification
REQ-032 A sends 8'hAA -> q_data_in pattern 1,0,1,0,1,0,1,0 each 15 clocks, q_write_in high 120 clocks, occupancy 1 after 170.
REQ-033 A and B both valid (8'hCC, 8'hF0) -> A served first, then B; occupancy 2.
REQ-034 Nine writes (AA,CC,F0,0F,33,55,99,FF,00) -> full after 8, ninth held with ready=0 until a dequeue frees space.
REQ-035 deq_req with queue empty from reset -> deq_ack+deq_err=1 next cycle, q_dequeue_in never rises.
REQ-036 deq_req and A valid same cycle with occupancy 3 -> DEQ first, 15-clock q_dequeue_in, deq_ack after 65 clocks, then SEND.
REQ-037 Reset low during SEND bit 4 -> outputs 0 immediately, occupancy 0, next write restarts from MSB.
